// File: rtl/vga_line_fetcher.sv
// Burst-read scheduler that keeps a show-ahead RGB pixel FIFO ahead of the VGA scanout.
// Optional build macro VGA_FETCH_STATS_EN adds a saturating underflow_count output.
module vga_line_fetcher #(
    parameter int C_addr_bits  = 20,
    parameter int C_line_words = 640,
    parameter int C_fifo_bits  = 5,
    parameter int C_burst      = 8
) (
    input  logic                   clk_pixel,
    input  logic                   rst_n,
    input  logic [C_addr_bits-1:0] base_addr,
    input  logic                   fetch_next,
    input  logic                   line_repeat,
    input  logic                   vga_vblank,
    output logic                   mem_req,
    output logic [C_addr_bits-1:0] mem_addr,
    input  logic                   mem_ack,
    input  logic                   mem_valid,
    input  logic [23:0]            mem_data,
    output logic [7:0]             red_byte,
    output logic [7:0]             green_byte,
    output logic [7:0]             blue_byte,
    output logic [C_fifo_bits:0]   fifo_level,
    output logic                   underflow
`ifdef VGA_FETCH_STATS_EN
    ,
    output logic [15:0]            underflow_count
`endif
);

    localparam int C_depth     = 2**C_fifo_bits;
    localparam int C_cnt_bits  = $clog2(C_line_words + 1);
    localparam int C_beat_bits = $clog2(C_burst + 1);
    localparam logic [C_fifo_bits:0]   C_level_max = (C_fifo_bits+1)'(C_depth - C_burst);
    localparam logic [C_addr_bits-1:0] C_line_inc  = C_addr_bits'(C_line_words);
    localparam logic [C_addr_bits-1:0] C_burst_inc = C_addr_bits'(C_burst);
    localparam logic [C_cnt_bits-1:0]  C_line_last = C_cnt_bits'(C_line_words - 1);
    localparam logic [C_cnt_bits-1:0]  C_cnt_one   = C_cnt_bits'(1);
    localparam logic [C_beat_bits-1:0] C_beat_last = C_beat_bits'(C_burst - 1);
    localparam logic [C_beat_bits-1:0] C_beat_one  = C_beat_bits'(1);
    localparam logic [C_fifo_bits-1:0] C_ptr_one   = C_fifo_bits'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RECV  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t                 state_r;
    logic                   repeat_prev_r;
    logic                   vblank_prev_r;
    logic                   repeat_pend_r;
    logic                   vblank_pend_r;
    logic [C_addr_bits-1:0] base_r;
    logic [C_addr_bits-1:0] fetch_addr_r;
    logic [C_addr_bits-1:0] cons_start_r;
    logic [C_addr_bits-1:0] prev_start_r;
    logic [C_cnt_bits-1:0]  pop_cnt_r;
    logic [C_beat_bits-1:0] beat_cnt_r;
    logic [C_fifo_bits-1:0] wr_ptr_r;
    logic [C_fifo_bits-1:0] rd_ptr_r;
    logic [23:0]            fifo_mem_r [C_depth];

    logic                   repeat_rise_s;
    logic                   vblank_rise_s;
    logic                   repeat_evt_s;
    logic                   vblank_evt_s;
    logic                   evt_any_s;
    logic [C_addr_bits-1:0] frame_base_s;
    logic                   fifo_empty_s;
    logic                   pop_ok_s;
    logic                   push_s;
    logic                   line_end_s;
    logic                   flush_s;
    logic [23:0]            head_s;

    // A rise seen this cycle counts as pending so IDLE can react without a cycle of lag.
    assign repeat_rise_s = line_repeat & ~repeat_prev_r;
    assign vblank_rise_s = vga_vblank & ~vblank_prev_r;
    assign repeat_evt_s  = repeat_pend_r | repeat_rise_s;
    assign vblank_evt_s  = vblank_pend_r | vblank_rise_s;
    assign evt_any_s     = repeat_evt_s | vblank_evt_s;
    assign frame_base_s  = vblank_rise_s ? base_addr : base_r;
    assign fifo_empty_s  = (fifo_level == {(C_fifo_bits+1){1'b0}});
    assign pop_ok_s      = fetch_next & ~fifo_empty_s;
    assign push_s        = (state_r == ST_RECV) & mem_valid & ~evt_any_s;
    assign line_end_s    = (pop_cnt_r == C_line_last);
    assign flush_s       = (state_r == ST_FLUSH);
    assign head_s        = fifo_mem_r[rd_ptr_r];

    // Fetch FSM: burst requests, beat counting, event latching and fetch address.
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            mem_req       <= 1'b0;
            mem_addr      <= {C_addr_bits{1'b0}};
            fetch_addr_r  <= {C_addr_bits{1'b0}};
            beat_cnt_r    <= {C_beat_bits{1'b0}};
            repeat_prev_r <= 1'b0;
            vblank_prev_r <= 1'b0;
            repeat_pend_r <= 1'b0;
            vblank_pend_r <= 1'b0;
            base_r        <= {C_addr_bits{1'b0}};
        end else begin
            repeat_prev_r <= line_repeat;
            vblank_prev_r <= vga_vblank;
            if (vblank_rise_s) begin
                base_r <= base_addr;
            end
            if (flush_s) begin
                repeat_pend_r <= 1'b0;
                vblank_pend_r <= 1'b0;
            end else begin
                repeat_pend_r <= repeat_evt_s;
                vblank_pend_r <= vblank_evt_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (evt_any_s) begin
                        state_r <= ST_FLUSH;
                    end else if (fifo_level <= C_level_max) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_addr_r;
                        state_r  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        beat_cnt_r <= {C_beat_bits{1'b0}};
                        state_r    <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (mem_valid) begin
                        if (beat_cnt_r == C_beat_last) begin
                            beat_cnt_r   <= {C_beat_bits{1'b0}};
                            fetch_addr_r <= fetch_addr_r + C_burst_inc;
                            state_r      <= evt_any_s ? ST_FLUSH : ST_IDLE;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + C_beat_one;
                        end
                    end
                end
                ST_FLUSH: begin
                    fetch_addr_r <= vblank_evt_s ? frame_base_s : prev_start_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Consumer line tracking; a flush rewinds to the frame base or the last completed line.
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            cons_start_r <= {C_addr_bits{1'b0}};
            prev_start_r <= {C_addr_bits{1'b0}};
            pop_cnt_r    <= {C_cnt_bits{1'b0}};
        end else if (flush_s) begin
            cons_start_r <= vblank_evt_s ? frame_base_s : prev_start_r;
            prev_start_r <= vblank_evt_s ? frame_base_s : prev_start_r;
            pop_cnt_r    <= {C_cnt_bits{1'b0}};
        end else if (fetch_next) begin
            if (line_end_s) begin
                prev_start_r <= cons_start_r;
                cons_start_r <= cons_start_r + C_line_inc;
                pop_cnt_r    <= {C_cnt_bits{1'b0}};
            end else begin
                pop_cnt_r <= pop_cnt_r + C_cnt_one;
            end
        end
    end

    // FIFO pointers and level.
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            wr_ptr_r   <= {C_fifo_bits{1'b0}};
            rd_ptr_r   <= {C_fifo_bits{1'b0}};
            fifo_level <= {(C_fifo_bits+1){1'b0}};
        end else if (flush_s) begin
            wr_ptr_r   <= {C_fifo_bits{1'b0}};
            rd_ptr_r   <= {C_fifo_bits{1'b0}};
            fifo_level <= {(C_fifo_bits+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + C_ptr_one;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + C_ptr_one;
            end
            fifo_level <= fifo_level + (C_fifo_bits+1)'(push_s) - (C_fifo_bits+1)'(pop_ok_s);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_pixel) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= mem_data;
        end
    end

    // Registered pixel output and sticky underflow flag.
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            red_byte   <= 8'h00;
            green_byte <= 8'h00;
            blue_byte  <= 8'h00;
            underflow  <= 1'b0;
        end else if (fetch_next) begin
            if (fifo_empty_s) begin
                red_byte   <= 8'h00;
                green_byte <= 8'h00;
                blue_byte  <= 8'h00;
                underflow  <= 1'b1;
            end else begin
                red_byte   <= head_s[23:16];
                green_byte <= head_s[15:8];
                blue_byte  <= head_s[7:0];
            end
        end
    end

`ifdef VGA_FETCH_STATS_EN
    // Saturating per-frame count of pops that found the FIFO empty.
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            underflow_count <= 16'h0000;
        end else if (vblank_rise_s) begin
            underflow_count <= 16'h0000;
        end else if (fetch_next && fifo_empty_s && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Randomized scoreboard bench for vga_line_fetcher: a framebuffer responder, an address
// model of the scanout and monitors for popped pixels and burst requests.
module tb_vga_line_fetcher;

    localparam int AB = 20;
    localparam int LW = 16;
    localparam int FB = 5;
    localparam int BU = 8;

    logic          clk_pixel = 1'b0;
    logic          rst_n;
    logic [AB-1:0] base_addr;
    logic          fetch_next;
    logic          line_repeat;
    logic          vga_vblank;
    logic          mem_req;
    logic [AB-1:0] mem_addr;
    logic          mem_ack;
    logic          mem_valid;
    logic [23:0]   mem_data;
    logic [7:0]    red_byte;
    logic [7:0]    green_byte;
    logic [7:0]    blue_byte;
    logic [FB:0]   fifo_level;
    logic          underflow;
`ifdef VGA_FETCH_STATS_EN
    logic [15:0]   underflow_count;
`endif

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [AB-1:0] m_cons;
    logic [AB-1:0] m_prev;
    logic [AB-1:0] m_req;
    logic [AB-1:0] req_hold;
    int            m_cnt;
    int            req_cnt;
    bit            resp_en;
    bit            req_prev = 1'b0;
    bit            pop_seen;
    logic [23:0]   exp_q[$];

    vga_line_fetcher #(
        .C_addr_bits (AB),
        .C_line_words(LW),
        .C_fifo_bits (FB),
        .C_burst     (BU)
    ) dut (
        .clk_pixel  (clk_pixel),
        .rst_n      (rst_n),
        .base_addr  (base_addr),
        .fetch_next (fetch_next),
        .line_repeat(line_repeat),
        .vga_vblank (vga_vblank),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .red_byte   (red_byte),
        .green_byte (green_byte),
        .blue_byte  (blue_byte),
        .fifo_level (fifo_level),
        .underflow  (underflow)
`ifdef VGA_FETCH_STATS_EN
        ,
        .underflow_count(underflow_count)
`endif
    );

    always #5 clk_pixel = ~clk_pixel;

    // Framebuffer contents: a distinct pixel for every word address.
    function automatic logic [23:0] pix(input logic [AB-1:0] a);
        return {a[7:0] ^ 8'hA1, a[15:8] ^ 8'hB2, {a[19:16], 4'h0} ^ 8'hC3};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scanout model: pixel k of the current line lives at line start + k.
    task automatic model_pop();
        logic [AB-1:0] a;
        a = m_cons + AB'(m_cnt);
        exp_q.push_back(pix(a));
        m_cnt++;
        if (m_cnt == LW) begin
            m_prev = m_cons;
            m_cons = m_cons + AB'(LW);
            m_cnt  = 0;
        end
    endtask

    // Called at a negedge; pops only when the FIFO holds data.
    task automatic pop_step(input int pct);
        if (fifo_level != '0 && $urandom_range(0, 99) < pct) begin
            fetch_next = 1'b1;
            model_pop();
        end else begin
            fetch_next = 1'b0;
        end
    endtask

    // Called at a negedge; raises the event(s), holds the level, then lets the flush settle.
    task automatic raise_event(input bit vb, input bit rp, input logic [AB-1:0] b);
        fetch_next  = 1'b0;
        base_addr   = b;
        vga_vblank  = vb;
        line_repeat = rp;
        if (vb) begin
            m_cons = b;
            m_prev = b;
            m_req  = b;
        end else begin
            m_cons = m_prev;
            m_req  = m_prev;
        end
        m_cnt   = 0;
        req_cnt = 0;
        repeat ($urandom_range(1, 4)) @(negedge clk_pixel);
        base_addr   = AB'($urandom);
        vga_vblank  = 1'b0;
        line_repeat = 1'b0;
        repeat (50) @(negedge clk_pixel);
    endtask

    // Memory responder: ack after a random delay, then BU beats with random gaps.
    initial begin
        logic [AB-1:0] a;
        forever begin
            @(negedge clk_pixel);
            if (resp_en && rst_n && mem_req) begin
                a = mem_addr;
                repeat ($urandom_range(0, 2)) @(negedge clk_pixel);
                mem_ack = 1'b1;
                @(negedge clk_pixel);
                mem_ack = 1'b0;
                for (int i = 0; i < BU; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk_pixel);
                    mem_valid = 1'b1;
                    mem_data  = pix(a + AB'(i));
                    @(negedge clk_pixel);
                    mem_valid = 1'b0;
                end
            end
        end
    end

    // Pixel monitor: one edge after a pop, the bytes must match the queued expectation.
    always @(posedge clk_pixel) begin
        pop_seen = fetch_next;
        #1;
        if (pop_seen) begin
            if (exp_q.size() == 0) begin
                check("pixel_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                check("pixel", {8'h00, red_byte, green_byte, blue_byte}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    // Request monitor: each new burst address follows the model; address held during req.
    always @(posedge clk_pixel) begin
        #1;
        if (mem_req && !req_prev) begin
            check("req_addr", 32'(mem_addr), 32'(m_req));
            m_req    = m_req + AB'(BU);
            req_hold = mem_addr;
            req_cnt++;
        end else if (mem_req) begin
            check("req_hold", 32'(mem_addr), 32'(req_hold));
        end
        req_prev = mem_req;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int kind;
        logic [AB-1:0] b;
        rst_n = 1'b0; base_addr = '0; fetch_next = 1'b0; line_repeat = 1'b0;
        vga_vblank = 1'b0; mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
        resp_en = 1'b0; m_cons = '0; m_prev = '0; m_req = '0; m_cnt = 0; req_cnt = 0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk_pixel);
            mem_valid = ~mem_valid;
            mem_data  = 24'($urandom);
        end
        @(negedge clk_pixel);
        mem_valid = 1'b0;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_bytes", {8'h00, red_byte, green_byte, blue_byte}, 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        rst_n = 1'b1;

        // First request is left unanswered so the FIFO stays empty.
        repeat (3) @(negedge clk_pixel);
        check("idle_underflow", 32'(underflow), 32'd0);
        check("idle_req", 32'(mem_req), 32'd1);
        fetch_next = 1'b1;
        exp_q.push_back(24'h000000);
        m_cnt++;
        @(negedge clk_pixel);
        fetch_next = 1'b0;
        check("uf_set", 32'(underflow), 32'd1);
        check("uf_level", 32'(fifo_level), 32'd0);
        repeat (2) @(negedge clk_pixel);
        check("uf_sticky", 32'(underflow), 32'd1);
`ifdef VGA_FETCH_STATS_EN
        check("uf_count", 32'(underflow_count), 32'd1);
`endif

        // Frame start lands while a burst is outstanding; its beats must be dropped.
        resp_en = 1'b1;
        raise_event(1'b1, 1'b0, 20'h00100);
        repeat (200) @(negedge clk_pixel);
        check("prefill_level", 32'(fifo_level), 32'd32);
        check("prefill_reqs", 32'(req_cnt), 32'd4);
        fetch_next = 1'b1;
        model_pop();
        @(negedge clk_pixel);
        fetch_next = 1'b0;
        check("pop_level", 32'(fifo_level), 32'd31);

        // Finish the first line, then repeat it.
        guard = 0;
        while (m_cnt != 0 && guard < 500) begin
            @(negedge clk_pixel);
            pop_step(100);
            guard++;
        end
        check("line_pop_timeout", 32'(guard < 500), 32'd1);
        @(negedge clk_pixel);
        raise_event(1'b0, 1'b1, base_addr);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_pixel);
            pop_step(75);
        end

        // Random scanout with random frame starts, repeats and simultaneous events.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_pixel);
            if ($urandom_range(0, 149) == 0) begin
                kind = $urandom_range(0, 3);
                b = ($urandom_range(0, 3) == 0) ? AB'(20'hFFFF0 + 20'($urandom_range(0, 15)))
                                                 : AB'($urandom);
                case (kind)
                    0: raise_event(1'b1, 1'b0, b);
                    1: raise_event(1'b0, 1'b1, b);
                    2: raise_event(1'b1, 1'b1, b);
                    default: raise_event(1'b0, 1'b1, b);
                endcase
            end else begin
                pop_step($urandom_range(30, 100));
            end
        end

        @(negedge clk_pixel);
        fetch_next = 1'b0;
        repeat (250) @(negedge clk_pixel);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        check("end_level_full", 32'(fifo_level), 32'd32);
        check("end_underflow_sticky", 32'(underflow), 32'd1);
`ifdef VGA_FETCH_STATS_EN
        check("end_uf_count", 32'(underflow_count), 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
